alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Execution unit that consumes the 3-bit ALUSel code from the ALU control decoder and performs the selected operation.
- Single-cycle ops (add/sub/and/or/sll/srl) complete in one cycle.
- mul/div run iteratively over WIDTH cycles.
- Uses a start/busy/done handshake so the datapath controller can stall while mul/div are in flight.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- SHAMT_W, 5, number of b LSBs used as shift amount (log2 WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  launch op; sampled only when busy=0.
- ALUSel  input  3  op code: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 sll, 111 srl.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- result  output  WIDTH  registered result of last completed op.
- zero  output  1  registered, result==0.
- busy  output  1  high while mul/div iterating.
- done  output  1  one-cycle pulse when result/zero updated.
- div_by_zero  output  1  registered; set on div with b==0, cleared on any other completion.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values: result=0, zero=1, busy=0, done=0, div_by_zero=0, state=IDLE, counter=0.
- States: IDLE, MUL, DIV.
- IDLE, start=1, single-cycle op (000/001/100/101/110/111):
  - result computed and registered at that edge; done=1 for the next cycle; state stays IDLE.
  - Latency 1.
- IDLE, start=1, ALUSel=010: latch a into multiplicand, b into multiplier, clear accumulator, counter=WIDTH, busy=1, go to MUL.
- IDLE, start=1, ALUSel=011, b≠0: latch dividend/divisor, clear remainder, counter=WIDTH, busy=1, go to DIV.
- IDLE, start=1, ALUSel=011, b==0: no iteration; result=all-ones, div_by_zero=1, done pulse next cycle. Latency 1.
- MUL:
  - Each edge: if multiplier LSB=1, accumulator += multiplicand.
  - Multiplicand shifts left 1, multiplier shifts right 1, counter decrements.
  - When counter reaches 0: result = low WIDTH bits of product, done=1, busy=0, go to IDLE.
  - Upper product bits are discarded.
- DIV:
  - Unsigned restoring division, one quotient bit per edge, MSB first.
  - Shift {rem, dividend} left 1; if rem ≥ divisor, subtract and set quotient bit.
  - After WIDTH iterations: result = quotient, done=1, busy=0, go to IDLE.
- mul/div latency: done high WIDTH+1 cycles after the cycle in which start was sampled. busy high for exactly WIDTH cycles.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH; no carry/overflow output.
  - sll/srl shift by b[SHAMT_W-1:0], logical, zero-fill.
  - and/or are bitwise.
- zero is updated together with result on every completion.
- div_by_zero holds until the next completion.
- done is a pure pulse: exactly 1 cycle per accepted start.
- start while busy=1 is ignored; no queueing. a/b/ALUSel changes during MUL/DIV have no effect (operands latched).
- start in the same cycle as done=1 is accepted (state is IDLE). Back-to-back single-cycle ops give done high on consecutive cycles.
- Unknown/illegal codes: none; all 8 decoded.
- rst mid-operation: aborts MUL/DIV at that edge, all outputs return to reset values, no done pulse.
- rst and start in the same cycle: rst wins, start is dropped.

Optional Feature:
- Macro: ALU_MULTICYCLE_REMAINDER_EN.
- Defined:
  - Extra output port remainder (WIDTH) is present, registered.
  - Updated on div completion with the final remainder.
  - On div-by-zero, remainder=a.
  - Cleared to 0 on reset and on completion of any non-div op.
- Undefined: port absent; remainder register is internal only and may be optimised away. All other behaviour identical.

Test Plan:
- Reset then idle: assert rst 2 cycles -> result=0, zero=1, busy=0, done=0, div_by_zero=0.
- add/sub/shift: start ALUSel=000 a=0xFFFFFFFF b=1 -> next cycle done=1, result=0, zero=1. Then sll a=1 b=0x23 -> result=0x8 (shamt=3).
- mul: start ALUSel=010 a=0x00010003 b=0x00020005 -> busy high 32 cycles, done at cycle 33, result=0x000B000F (low bits of product). start asserted mid-op with add -> ignored; result unchanged by it.
- div: start ALUSel=011 a=100 b=7 -> done after 33 cycles, result=14, div_by_zero=0; with ALU_MULTICYCLE_REMAINDER_EN, remainder=2.
- div by zero: a=5 b=0 -> done next cycle, result=0xFFFFFFFF, div_by_zero=1 (remainder=5 if macro defined). Following or op -> div_by_zero=0.
- Reset mid-op: start mul, assert rst at iteration 10 -> busy=0 and result=0 next cycle, no done pulse. New start accepted the cycle after rst deasserts.

Source files
------------

// File: rtl/alu_multicycle.sv
// Execution unit: single-cycle add/sub/and/or/sll/srl, iterative mul/div with start/busy/done handshake.
// Optional remainder output port enabled by defining ALU_MULTICYCLE_REMAINDER_EN.
module alu_multicycle #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ALUSel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
`ifdef ALU_MULTICYCLE_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] remainder
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_op_a_nxt;
  logic [WIDTH-1:0] w_op_b_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_done;
  logic             r_dbz;
  logic             w_fin;
  logic [WIDTH-1:0] w_fin_val;
  logic             w_fin_dbz;
  logic [WIDTH-1:0] w_mul_sum;
  logic [WIDTH-1:0] w_div_sh;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_sub;
`ifdef ALU_MULTICYCLE_REMAINDER_EN
  logic [WIDTH-1:0] r_rem_out;
  logic [WIDTH-1:0] w_fin_rem;
`endif

  // Multiplier and divider datapath: r_op_a/r_op_b/r_acc are shared between both iterative ops.
  assign w_mul_sum = r_acc + (r_op_b[0] ? r_op_a : '0);
  assign w_div_sh  = {r_acc[WIDTH-2:0], r_op_a[WIDTH-1]};
  // Shifted remainder is WIDTH+1 bits; a set top bit always exceeds the divisor.
  assign w_div_ge  = r_acc[WIDTH-1] | (w_div_sh >= r_op_b);
  assign w_div_sub = w_div_sh - r_op_b;

  // Next-state, operand-latch and completion decode.
  always_comb begin
    w_state_nxt = r_state;
    w_op_a_nxt  = r_op_a;
    w_op_b_nxt  = r_op_b;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_fin       = 1'b0;
    w_fin_val   = '0;
    w_fin_dbz   = 1'b0;
`ifdef ALU_MULTICYCLE_REMAINDER_EN
    w_fin_rem   = '0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_fin = 1'b1;
          case (ALUSel)
            3'b000: w_fin_val = a + b;
            3'b001: w_fin_val = a - b;
            3'b010: begin
              w_fin       = 1'b0;
              w_op_a_nxt  = a;
              w_op_b_nxt  = b;
              w_acc_nxt   = '0;
              w_cnt_nxt   = CNT_W'(WIDTH);
              w_busy_nxt  = 1'b1;
              w_state_nxt = ST_MUL;
            end
            3'b011: begin
              if (b == '0) begin
                w_fin_val = '1;
                w_fin_dbz = 1'b1;
`ifdef ALU_MULTICYCLE_REMAINDER_EN
                w_fin_rem = a;
`endif
              end else begin
                w_fin       = 1'b0;
                w_op_a_nxt  = a;
                w_op_b_nxt  = b;
                w_acc_nxt   = '0;
                w_cnt_nxt   = CNT_W'(WIDTH);
                w_busy_nxt  = 1'b1;
                w_state_nxt = ST_DIV;
              end
            end
            3'b100: w_fin_val = a & b;
            3'b101: w_fin_val = a | b;
            3'b110: w_fin_val = a << b[SHAMT_W-1:0];
            3'b111: w_fin_val = a >> b[SHAMT_W-1:0];
            default: w_fin_val = '0;
          endcase
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MUL: begin
        w_acc_nxt  = w_mul_sum;
        w_op_a_nxt = r_op_a << 1;
        w_op_b_nxt = r_op_b >> 1;
        w_cnt_nxt  = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_fin       = 1'b1;
          w_fin_val   = w_mul_sum;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_MUL;
        end
      end
      ST_DIV: begin
        w_acc_nxt  = w_div_ge ? w_div_sub : w_div_sh;
        w_op_a_nxt = {r_op_a[WIDTH-2:0], w_div_ge};
        w_cnt_nxt  = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_fin       = 1'b1;
          w_fin_val   = {r_op_a[WIDTH-2:0], w_div_ge};
`ifdef ALU_MULTICYCLE_REMAINDER_EN
          w_fin_rem   = w_div_ge ? w_div_sub : w_div_sh;
`endif
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DIV;
        end
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Iteration registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_dbz    <= 1'b0;
`ifdef ALU_MULTICYCLE_REMAINDER_EN
      r_rem_out <= '0;
`endif
    end else begin
      r_op_a <= w_op_a_nxt;
      r_op_b <= w_op_b_nxt;
      r_acc  <= w_acc_nxt;
      r_cnt  <= w_cnt_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_fin;
      if (w_fin) begin
        r_result <= w_fin_val;
        r_zero   <= (w_fin_val == '0);
        r_dbz    <= w_fin_dbz;
`ifdef ALU_MULTICYCLE_REMAINDER_EN
        r_rem_out <= w_fin_rem;
`endif
      end
    end
  end

  assign result      = r_result;
  assign zero        = r_zero;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
`ifdef ALU_MULTICYCLE_REMAINDER_EN
  assign remainder   = r_rem_out;
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed literal cases plus random stimulus
// against a cycle-level arithmetic model (remainder checked when ALU_MULTICYCLE_REMAINDER_EN is defined).
module tb_alu_multicycle;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   ALUSel;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;
  logic         done;
  logic         div_by_zero;
`ifdef ALU_MULTICYCLE_REMAINDER_EN
  logic [W-1:0] remainder;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .ALUSel(ALUSel),
    .a(a),
    .b(b),
    .result(result),
    .zero(zero),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero)
`ifdef ALU_MULTICYCLE_REMAINDER_EN
    ,
    .remainder(remainder)
`endif
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: outputs after each edge, with a countdown for mul/div in flight.
  logic [W-1:0] m_result;
  logic         m_zero;
  logic         m_busy;
  logic         m_done;
  logic         m_dbz;
  logic [W-1:0] m_rem;
  logic [W-1:0] m_pres;
  logic [W-1:0] m_prem;
  int           m_pending = 0;
  bit           m_valid = 1'b0;

  function automatic void m_complete(input logic [W-1:0] v, input logic dz, input logic [W-1:0] r);
    m_result = v;
    m_zero   = (v == 32'd0);
    m_done   = 1'b1;
    m_dbz    = dz;
    m_rem    = r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_result = 32'd0; m_zero = 1'b1; m_busy = 1'b0; m_done = 1'b0;
      m_dbz = 1'b0; m_rem = 32'd0; m_pending = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_done = 1'b0;
      if (m_pending > 0) begin
        m_pending--;
        if (m_pending == 0) begin
          m_complete(m_pres, 1'b0, m_prem);
          m_busy = 1'b0;
        end
      end else if (start) begin
        case (ALUSel)
          3'd0: m_complete(a + b, 1'b0, 32'd0);
          3'd1: m_complete(a - b, 1'b0, 32'd0);
          3'd2: begin m_pres = a * b; m_prem = 32'd0; m_pending = W; m_busy = 1'b1; end
          3'd3: begin
            if (b == 32'd0) m_complete(32'hFFFF_FFFF, 1'b1, a);
            else begin m_pres = a / b; m_prem = a % b; m_pending = W; m_busy = 1'b1; end
          end
          3'd4: m_complete(a & b, 1'b0, 32'd0);
          3'd5: m_complete(a | b, 1'b0, 32'd0);
          3'd6: m_complete(a << b[4:0], 1'b0, 32'd0);
          default: m_complete(a >> b[4:0], 1'b0, 32'd0);
        endcase
      end
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("result", result, m_result);
      chk("zero", 32'(zero), 32'(m_zero));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
`ifdef ALU_MULTICYCLE_REMAINDER_EN
      chk("remainder", remainder, m_rem);
`endif
    end
  end

  task automatic drive(input logic s, input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    start = s; ALUSel = op; a = x; b = y;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; ALUSel = 3'd0; a = 32'd0; b = 32'd0;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    chk("lit_rst_result", result, 32'd0);
    chk("lit_rst_zero", 32'(zero), 32'd1);
    chk("lit_rst_busy", 32'(busy), 32'd0);
    chk("lit_rst_done", 32'(done), 32'd0);
    chk("lit_rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    drive(1'b1, 3'b000, 32'hFFFF_FFFF, 32'd1);
    chk("lit_add_done", 32'(done), 32'd1);
    chk("lit_add_result", result, 32'd0);
    chk("lit_add_zero", 32'(zero), 32'd1);
    drive(1'b1, 3'b110, 32'd1, 32'h23);
    chk("lit_sll_result", result, 32'd8);
    chk("lit_sll_done", 32'(done), 32'd1);

    drive(1'b1, 3'b010, 32'h0001_0003, 32'h0002_0005);
    chk("lit_mul_busy", 32'(busy), 32'd1);
    n = 1;
    while (!done && n < 40) begin
      drive((n < 4) ? 1'b1 : 1'b0, 3'b000, 32'd7, 32'd9);
      n++;
    end
    chk("lit_mul_latency", 32'(n), 32'd33);
    chk("lit_mul_result", result, 32'h000B_000F);
    chk("lit_mul_model", m_result, 32'h000B_000F);
    chk("lit_mul_busy_low", 32'(busy), 32'd0);

    drive(1'b1, 3'b011, 32'd100, 32'd7);
    n = 1;
    while (!done && n < 40) begin
      drive(1'b0, 3'b000, 32'd0, 32'd0);
      n++;
    end
    chk("lit_div_latency", 32'(n), 32'd33);
    chk("lit_div_result", result, 32'd14);
    chk("lit_div_dbz", 32'(div_by_zero), 32'd0);
`ifdef ALU_MULTICYCLE_REMAINDER_EN
    chk("lit_div_rem", remainder, 32'd2);
`endif

    drive(1'b1, 3'b011, 32'd5, 32'd0);
    chk("lit_dbz_done", 32'(done), 32'd1);
    chk("lit_dbz_result", result, 32'hFFFF_FFFF);
    chk("lit_dbz_flag", 32'(div_by_zero), 32'd1);
`ifdef ALU_MULTICYCLE_REMAINDER_EN
    chk("lit_dbz_rem", remainder, 32'd5);
`endif
    drive(1'b1, 3'b101, 32'd1, 32'd2);
    chk("lit_or_result", result, 32'd3);
    chk("lit_or_dbz", 32'(div_by_zero), 32'd0);

    drive(1'b1, 3'b010, 32'h1234, 32'h5678);
    for (int i = 0; i < 9; i++) drive(1'b0, 3'b000, 32'd0, 32'd0);
    rst = 1'b1;
    drive(1'b1, 3'b000, 32'd4, 32'd4);
    chk("lit_abort_busy", 32'(busy), 32'd0);
    chk("lit_abort_result", result, 32'd0);
    chk("lit_abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    drive(1'b1, 3'b000, 32'd2, 32'd3);
    chk("lit_after_rst_result", result, 32'd5);
    chk("lit_after_rst_done", 32'(done), 32'd1);

    for (int i = 0; i < 4000; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 20);
        2: rb = ra >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      rst = ($urandom_range(0, 299) == 0);
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, rb);
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) drive(1'b0, 3'd0, 32'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
